// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI mode-0 initiator framing {cmd, addr, data} register transactions
module spi_master_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int SPI_ADDR_WIDTH = 8,
    parameter int CLK_DIV        = 4,
    parameter int CS_GAP         = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_read,
    input  logic [SPI_ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    output logic                      done,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      spi_sclk,
    output logic                      spi_cs_n,
    output logic                      spi_mosi,
    input  logic                      spi_miso
);
    localparam int N    = 1 + SPI_ADDR_WIDTH + DATA_WIDTH;
    localparam int CMAX = CLK_DIV > CS_GAP ? CLK_DIV : CS_GAP;
    localparam int CW   = $clog2(CMAX);
    localparam int BW   = $clog2(N);

    if (CLK_DIV < 2 || CS_GAP < 4) begin : g_bad_params
        $error("spi_master_ctrl: CLK_DIV must be >= 2 and CS_GAP >= 4");
    end

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t                state, state_d;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         bit_cnt;
    logic [N-1:0]          tx;
    logic [N-1:0]          frame;
    logic [DATA_WIDTH-1:0] rx;
    logic                  rd_q;
    logic                  accept, half_end, gap_end, last_bit, rise, fall;

    // Next-state decode plus SCLK edge strobes derived from the half-period counter
    always_comb begin
        accept   = req_valid && req_ready;
        half_end = cnt == CW'(CLK_DIV - 1);
        gap_end  = cnt == CW'(CS_GAP - 1);
        last_bit = bit_cnt == BW'(N - 1);
        rise     = half_end && (state == SETUP || (state == SHIFT && !spi_sclk));
        fall     = half_end && state == SHIFT && spi_sclk;
        frame    = {req_read, req_addr, req_read ? {DATA_WIDTH{1'b0}} : req_wdata};
        state_d  = state;
        case (state)
            IDLE:    state_d = accept ? SETUP : IDLE;
            SETUP:   state_d = half_end ? SHIFT : SETUP;
            SHIFT:   state_d = (fall && last_bit) ? HOLD : SHIFT;
            HOLD:    state_d = half_end ? GAP : HOLD;
            GAP:     state_d = gap_end ? IDLE : GAP;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    // Phase counter restarts on every state change and every SCLK edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else          cnt <= (state == IDLE || state_d != state || rise || fall) ? '0 : cnt + 1'b1;
    end

    // Pin drivers, shift registers and handshake outputs, all flopped so the pins never glitch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_ready <= 1'b0;
            done      <= 1'b0;
            rd_data   <= '0;
            spi_sclk  <= 1'b0;
            spi_cs_n  <= 1'b1;
            spi_mosi  <= 1'b0;
            tx        <= '0;
            rx        <= '0;
            rd_q      <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            req_ready <= state_d == IDLE;
            done      <= state == HOLD && half_end;
            if (accept) begin
                rd_q     <= req_read;
                spi_cs_n <= 1'b0;
                spi_mosi <= frame[N-1];
                tx       <= frame << 1;
                bit_cnt  <= '0;
            end
            if (rise) begin
                spi_sclk <= 1'b1;
                rx       <= {rx[DATA_WIDTH-2:0], spi_miso};
            end
            if (fall) begin
                spi_sclk <= 1'b0;
                if (!last_bit) begin
                    spi_mosi <= tx[N-1];
                    tx       <= tx << 1;
                    bit_cnt  <= bit_cnt + 1'b1;
                end
            end
            if (state == HOLD && half_end) begin
                spi_cs_n <= 1'b1;
                spi_mosi <= 1'b0;
                if (rd_q) rd_data <= rx;
            end
        end
    end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: directed checks of spi_master_ctrl against a behavioural SPI register peripheral
module tb_spi_master_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_read;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        done;
    logic [31:0] rd_data;
    logic        spi_sclk, spi_cs_n, spi_mosi, spi_miso;

    int checks = 0;
    int errors = 0;

    spi_master_ctrl #(.DATA_WIDTH(32), .SPI_ADDR_WIDTH(8), .CLK_DIV(2), .CS_GAP(4)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_read(req_read), .req_addr(req_addr), .req_wdata(req_wdata), .done(done),
        .rd_data(rd_data), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    // Cycle bookkeeping: cycle c is the interval after the c-th rising clock edge
    int cyc = 0;
    int accs = 0, last_acc = 0, prev_acc = 0;
    int dones = 0, done_cyc = 0;
    int cs_fall = 0, cs_rise = 0;
    logic prev_cs = 1'b1;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (reset_n && req_valid && req_ready) begin
            prev_acc = last_acc;
            last_acc = cyc;
            accs++;
        end
        if (done) begin
            dones++;
            done_cyc = cyc;
        end
        if (prev_cs && !spi_cs_n) cs_fall = cyc;
        if (!prev_cs && spi_cs_n) cs_rise = cyc;
        prev_cs = spi_cs_n;
    end

    // Peripheral model: samples MOSI on SCLK rise, presents read data on MISO, commits writes at CS_N rise
    logic [31:0] mem [0:255];
    logic [40:0] sh = '0;
    logic [31:0] rd_word = '0;
    logic        is_rd = 1'b0;
    int          k = 0;
    int          wstb = 0;

    always @(negedge spi_cs_n) begin
        k = 0;
        is_rd = 1'b0;
    end

    always @(posedge spi_sclk) begin
        sh = {sh[39:0], spi_mosi};
        k++;
        if (k == 9) begin
            is_rd = sh[8];
            rd_word = mem[sh[7:0]];
        end
    end

    always @(posedge spi_cs_n) begin
        if (k == 41 && !sh[40]) begin
            mem[sh[39:32]] = sh[31:0];
            wstb++;
        end
    end

    assign spi_miso = (is_rd && k >= 9 && k <= 40) ? rd_word[40-k] : 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic rd, input logic [7:0] a, input logic [31:0] d);
        int d0;
        for (int i = 0; i < 50 && !req_ready; i++) tick();
        d0 = dones;
        req_read = rd;
        req_addr = a;
        req_wdata = d;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 400 && dones == d0; i++) tick();
        chk("done_seen", 64'(dones), 64'(d0 + 1));
        repeat (6) tick();
    endtask

    int t, d0, a0, w0, r1;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[3] = 32'hA5A50F0F;
        reset_n = 1'b0;
        req_valid = 1'b0;
        req_read = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        repeat (3) tick();
        chk("rst_cs_n", 64'(spi_cs_n), 64'd1);
        chk("rst_sclk", 64'(spi_sclk), 64'd0);
        chk("rst_mosi", 64'(spi_mosi), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        reset_n = 1'b1;
        tick();
        chk("ready_after_rst", 64'(req_ready), 64'd1);

        // Write frame: bit stream and timing
        do_req(1'b0, 8'h05, 32'hDEADBEEF);
        t = last_acc;
        chk("w1_bits", 64'(sh), 64'({1'b0, 8'h05, 32'hDEADBEEF}));
        chk("w1_rises", 64'(k), 64'd41);
        chk("w1_cs_fall", 64'(cs_fall), 64'(t + 1));
        chk("w1_cs_rise", 64'(cs_rise), 64'(t + 167));
        chk("w1_done_cyc", 64'(done_cyc), 64'(t + 167));
        chk("w1_mem", 64'(mem[5]), 64'h0DEADBEEF);
        chk("w1_rd_data", 64'(rd_data), 64'd0);

        // Read frame: captured data and zeroed MOSI data field
        do_req(1'b1, 8'h03, 32'hFFFFFFFF);
        t = last_acc;
        chk("r2_rd_data", 64'(rd_data), 64'hA5A50F0F);
        chk("r2_hdr", 64'(sh[40:32]), 64'h103);
        chk("r2_mosi_data", 64'(sh[31:0]), 64'd0);
        chk("r2_done_cyc", 64'(done_cyc), 64'(t + 167));

        // Back-to-back with req_valid held high
        a0 = accs;
        req_read = 1'b0;
        req_addr = 8'h11;
        req_wdata = 32'h12345678;
        req_valid = 1'b1;
        for (int i = 0; i < 50 && accs == a0; i++) tick();
        req_addr = 8'h12;
        req_wdata = 32'h9ABCDEF0;
        for (int i = 0; i < 400 && accs < a0 + 2; i++) tick();
        req_valid = 1'b0;
        chk("b2b_accepts", 64'(accs), 64'(a0 + 2));
        chk("b2b_after_done", 64'(last_acc - done_cyc), 64'd4);
        chk("b2b_spacing", 64'(last_acc - prev_acc), 64'd171);
        r1 = cs_rise;
        d0 = dones;
        for (int i = 0; i < 400 && dones == d0; i++) tick();
        repeat (6) tick();
        chk("b2b_cs_gap", 64'(cs_fall - r1 >= 4), 64'd1);
        chk("b2b_mem_a", 64'(mem[8'h11]), 64'h12345678);
        chk("b2b_mem_b", 64'(mem[8'h12]), 64'h9ABCDEF0);

        // Reset mid-frame after rising edge 20
        d0 = dones;
        w0 = wstb;
        req_read = 1'b0;
        req_addr = 8'h30;
        req_wdata = 32'h55AA55AA;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 200 && k < 21; i++) tick();
        chk("rst4_reached_edge", 64'(k), 64'd21);
        reset_n = 1'b0;
        #1;
        chk("rst4_cs_n", 64'(spi_cs_n), 64'd1);
        chk("rst4_sclk", 64'(spi_sclk), 64'd0);
        chk("rst4_ready", 64'(req_ready), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("rst4_ready_after", 64'(req_ready), 64'd1);
        repeat (200) tick();
        chk("rst4_no_done", 64'(dones), 64'(d0));
        chk("rst4_no_write", 64'(wstb), 64'(w0));
        chk("rst4_mem", 64'(mem[8'h30]), 64'd0);

        // Loopback write then read through the peripheral
        w0 = wstb;
        do_req(1'b0, 8'h10, 32'h00000021);
        chk("lb_wstb", 64'(wstb), 64'(w0 + 1));
        do_req(1'b1, 8'h10, 32'h0);
        chk("lb_rd_data", 64'(rd_data), 64'h21);
        chk("lb_wstb_read", 64'(wstb), 64'(w0 + 1));

        // Write after read leaves rd_data, timing as in the first write
        do_req(1'b0, 8'h07, 32'h0);
        t = last_acc;
        chk("w6_rd_data", 64'(rd_data), 64'h21);
        chk("w6_bits", 64'(sh), 64'({1'b0, 8'h07, 32'h0}));
        chk("w6_rises", 64'(k), 64'd41);
        chk("w6_cs_fall", 64'(cs_fall), 64'(t + 1));
        chk("w6_done_cyc", 64'(done_cyc), 64'(t + 167));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
